// File: rtl/mem_store_align.sv
// ----------------------------------------------------------------------------
// mem_store_align
//
// Store-side alignment unit between the core MEM stage and the DMEM/IO write
// port. Each accepted store request (byte address, LSB-justified data, funct3)
// is turned into one or two word-aligned write beats carrying lane-shifted
// data and per-byte write enables. A store whose bytes spill past the end of
// its word is split into two beats; the second beat is held internally until
// the first has been consumed. All write-port outputs are registered.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | no beat presented; ready to accept a request
//   S_FIRST | presenting beat0 of a split store; beat1 held internally
//   S_LAST  | presenting the final (or only) beat; may accept the next
//           | request in the same cycle the beat is consumed
//
// Ports:
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous active-high reset
//   req_valid  in   1           store request valid
//   req_ready  out  1           request accepted when req_valid && req_ready
//   req_addr   in   ADDR_WIDTH  byte address
//   req_data   in   32          store data, LSB-justified
//   req_func   in   3           funct3 (SB / SH / SW)
//   mem_valid  out  1           write beat valid
//   mem_ready  in   1           beat consumed when mem_valid && mem_ready
//   mem_addr   out  ADDR_WIDTH  word-aligned beat address
//   mem_wdata  out  32          lane-shifted write data, disabled bytes zero
//   mem_we     out  4           byte enables, bit i -> mem_wdata[8i+7:8i]
//   split      out  1           current beat is the first of a split pair
// ----------------------------------------------------------------------------
module mem_store_align #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [2:0]            req_func,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_we,
    output logic                  split
);

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_LAST  = 2'd2
    } state_t;

    state_t state;

    // Second beat of a split store, waiting for beat0 to be consumed.
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [31:0]           hold_wdata;
    logic [3:0]            hold_we;

    // ------------------------------------------------------------------
    // Lane math for the request currently on the input port
    // ------------------------------------------------------------------
    logic [1:0]            lane_off;
    logic [3:0]            size_mask;
    logic                  func_ok;
    logic [31:0]           data_masked;
    logic [7:0]            we8;
    logic [63:0]           d64;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  has_beat1;

    always_comb begin
        size_mask = 4'b0000;
        func_ok   = 1'b1;
        case (req_func)
            FNC_SB:  size_mask = 4'b0001;
            FNC_SH:  size_mask = 4'b0011;
            FNC_SW:  size_mask = 4'b1111;
            default: func_ok   = 1'b0;
        endcase
    end

    assign lane_off = req_addr[1:0];

    // rs2 arrives as a full register; bytes beyond the access size are
    // cleared so disabled lanes always carry zeros.
    assign data_masked = req_data & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                     {8{size_mask[1]}}, {8{size_mask[0]}}};

    // Shifting into a double-word window lets the upper half fall out as the
    // second beat without any special-casing per access size.
    assign we8 = {4'b0000, size_mask} << lane_off;
    assign d64 = {32'h0000_0000, data_masked} << {lane_off, 3'b000};

    assign base_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign next_addr = base_addr + ADDR_WIDTH'(4);   // wraps at the top of the address space
    assign has_beat1 = |we8[7:4];

    // ------------------------------------------------------------------
    // Request handshake
    // ------------------------------------------------------------------
    // In S_LAST the slot frees exactly when the presented beat is consumed,
    // which allows one aligned store per cycle.
    always_comb begin
        req_ready = 1'b0;
        case (state)
            S_IDLE:  req_ready = 1'b1;
            S_FIRST: req_ready = 1'b0;
            S_LAST:  req_ready = mem_ready;
            default: req_ready = 1'b0;
        endcase
    end

    logic accept;
    logic load_new;

    assign accept   = req_valid && req_ready;
    // Unsupported funct3 is still accepted but produces no beat.
    assign load_new = accept && func_ok;

    // ------------------------------------------------------------------
    // FSM and registered write-port outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0000_0000;
            mem_we     <= 4'b0000;
            split      <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= 32'h0000_0000;
            hold_we    <= 4'b0000;
        end else if (load_new) begin
            // Reachable from S_IDLE, or from S_LAST while its beat is consumed.
            mem_valid <= 1'b1;
            mem_addr  <= base_addr;
            mem_wdata <= d64[31:0];
            mem_we    <= we8[3:0];
            split     <= has_beat1;
            if (has_beat1) begin
                hold_addr  <= next_addr;
                hold_wdata <= d64[63:32];
                hold_we    <= we8[7:4];
                state      <= S_FIRST;
            end else begin
                state      <= S_LAST;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    mem_valid <= 1'b0;
                end
                S_FIRST: begin
                    if (mem_ready) begin
                        mem_addr  <= hold_addr;
                        mem_wdata <= hold_wdata;
                        mem_we    <= hold_we;
                        split     <= 1'b0;
                        state     <= S_LAST;
                    end
                end
                S_LAST: begin
                    // Output registers keep their last contents while idle.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_align.sv
// ----------------------------------------------------------------------------
// tb_mem_store_align
//
// Scoreboard bench for mem_store_align. Directed cases push hand-computed
// beats; random traffic pushes beats from a byte-by-byte reference model.
// A monitor pops and compares on every write-port handshake and also checks
// output stability under back-pressure and req_ready during split beat0.
// ----------------------------------------------------------------------------
module tb_mem_store_align;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_func;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        split;

    mem_store_align #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_func  (req_func),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .split     (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        split;
    } beat_t;

    beat_t exp_q[$];

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    rdy_rand = 0;
    bit    b2b_on   = 0;
    int    b2b_cnt  = 0;
    int    b2b_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] we, input logic sp);
        beat_t b;
        b.addr = a; b.wdata = d; b.we = we; b.split = sp;
        exp_q.push_back(b);
    endtask

    // Reference model: place each stored byte at its own byte address and
    // group the bytes by the word they land in.
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f);
        int          n;
        logic [31:0] ba;
        logic [31:0] w0;
        beat_t       b0;
        beat_t       b1;
        case (f)
            SB:      n = 1;
            SH:      n = 2;
            SW:      n = 4;
            default: n = 0;
        endcase
        if (n == 0) return;
        w0 = a & 32'hFFFF_FFFC;
        b0.addr = w0;          b0.wdata = 32'h0; b0.we = 4'h0; b0.split = 1'b0;
        b1.addr = w0 + 32'd4;  b1.wdata = 32'h0; b1.we = 4'h0; b1.split = 1'b0;
        for (int i = 0; i < n; i++) begin
            int lane;
            ba   = a + 32'(i);
            lane = int'(ba[1:0]);
            if ((ba & 32'hFFFF_FFFC) == w0) begin
                b0.wdata[8*lane +: 8] = d[8*i +: 8];
                b0.we[lane] = 1'b1;
            end else begin
                b1.wdata[8*lane +: 8] = d[8*i +: 8];
                b1.we[lane] = 1'b1;
            end
        end
        if (b1.we != 4'h0) begin
            b0.split = 1'b1;
            exp_q.push_back(b0);
            exp_q.push_back(b1);
        end else begin
            exp_q.push_back(b0);
        end
    endfunction

    // Drive a request and hold it until accepted. Leaves req_valid high so
    // consecutive calls produce back-to-back requests; returns at edge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input bit use_model, output int tries);
        bit acc;
        acc   = 0;
        tries = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_func  = f;
        while (!acc && tries < 1000) begin
            @(negedge clk);
            acc = req_ready;
            tries++;
            if (acc && use_model) model(a, d, f);
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // mem_ready randomiser, active only during random traffic
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard
    initial begin
        bit    hold_prev;
        beat_t snap;
        beat_t e;
        hold_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 0;
            end else begin
                if (mem_valid && split) chk("ready_in_first", 64'(req_ready), 64'd0);
                if (hold_prev) begin
                    chk("stable", {mem_valid, split, mem_we, mem_addr, mem_wdata[22:0]},
                        {1'b1, snap.split, snap.we, snap.addr, snap.wdata[22:0]});
                    chk("stable_hi", 64'(mem_wdata), 64'(snap.wdata));
                end
                if (mem_valid && mem_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got addr=%h wdata=%h we=%b split=%b expected no beat",
                                 mem_addr, mem_wdata, mem_we, split);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_addr !== e.addr || mem_wdata !== e.wdata ||
                            mem_we !== e.we || split !== e.split) begin
                            errors++;
                            $display("FAIL beat: got addr=%h wdata=%h we=%b split=%b expected addr=%h wdata=%h we=%b split=%b",
                                     mem_addr, mem_wdata, mem_we, split, e.addr, e.wdata, e.we, e.split);
                        end
                    end
                    if (b2b_on) begin
                        if (b2b_cnt > 0) chk("b2b_gap", 64'(cyc - b2b_last), 64'd1);
                        b2b_cnt++;
                        b2b_last = cyc;
                    end
                end
                hold_prev = mem_valid && !mem_ready;
                snap.addr = mem_addr; snap.wdata = mem_wdata;
                snap.we = mem_we; snap.split = split;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          tries;
        int          fsel;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;

        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0;
        req_func = SB; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {mem_valid, split, mem_we, req_ready},
            {1'b0, 1'b0, 4'b0000, 1'b1});
        chk("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: aligned SW, beat valid the cycle after accept
        mem_ready = 1'b1;
        push_beat(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0);
        send(32'h100, 32'hDEADBEEF, SW, 0, tries);
        req_valid = 1'b0;
        chk("t1_latency", 64'(mem_valid), 64'd1);
        drain("t1");

        // 2: SB in top lane
        push_beat(32'h200, 32'hA500_0000, 4'b1000, 1'b0);
        send(32'h203, 32'h0000_00A5, SB, 0, tries);
        req_valid = 1'b0;
        drain("t2");

        // 3: SH crossing a word
        push_beat(32'h100, 32'h3400_0000, 4'b1000, 1'b1);
        push_beat(32'h104, 32'h0000_0012, 4'b0001, 1'b0);
        send(32'h103, 32'h0000_1234, SH, 0, tries);
        req_valid = 1'b0;
        drain("t3");

        // 4: split SW under back-pressure
        mem_ready = 1'b0;
        push_beat(32'h100, 32'hCCDD_0000, 4'b1100, 1'b1);
        push_beat(32'h104, 32'h0000_AABB, 4'b0011, 1'b0);
        send(32'h102, 32'hAABBCCDD, SW, 0, tries);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_held_first", {mem_valid, split, req_ready}, {1'b1, 1'b1, 1'b0});
        mem_ready = 1'b1;
        drain("t4");

        // 5: four back-to-back aligned SW, no bubbles
        b2b_on = 1; b2b_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h300 + 32'(4 * i);
            d = $urandom;
            push_beat(a, d, 4'b1111, 1'b0);
            send(a, d, SW, 0, tries);
            chk("t5_accept_first_try", 64'(tries), 64'd1);
        end
        req_valid = 1'b0;
        drain("t5");
        b2b_on = 0;
        chk("t5_beats", 64'(b2b_cnt), 64'd4);

        // 6: reset while in FIRST drops the held beat
        mem_ready = 1'b0;
        send(32'h103, 32'h0000_1234, SH, 0, tries);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_first", {mem_valid, split}, {1'b1, 1'b1});
        rst = 1'b1;
        #1;
        chk("t6_rst_async", {mem_valid, split, mem_we, mem_addr}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_beat1", 64'(mem_valid), 64'd0);
        push_beat(32'h0, 32'h0000_007F, 4'b0001, 1'b0);
        send(32'h0, 32'h0000_007F, SB, 0, tries);
        req_valid = 1'b0;
        drain("t6");

        // unsupported funct3: accepted, no beat
        send(32'h40, 32'h1234_5678, 3'b111, 0, tries);
        req_valid = 1'b0;
        chk("unsup_accept", 64'(tries), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("unsup_no_beat", 64'(mem_valid), 64'd0);

        // SW at the top of the address space: beat1 wraps to 0
        push_beat(32'hFFFF_FFFC, 32'h4400_0000, 4'b1000, 1'b1);
        push_beat(32'h0000_0000, 32'h0011_2233, 4'b0111, 1'b0);
        send(32'hFFFF_FFFF, 32'h1122_3344, SW, 0, tries);
        req_valid = 1'b0;
        drain("wrap");

        // random traffic
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            fsel = $urandom_range(0, 9);
            if (fsel < 3)      f = SB;
            else if (fsel < 6) f = SH;
            else if (fsel < 9) f = SW;
            else               f = 3'(3 + $urandom_range(0, 4));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            d = $urandom;
            send(a, d, f, 1, tries);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        rdy_rand = 0;
        #2;
        mem_ready = 1'b1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
